// File: rtl/count8_down_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count8_down_pkg
// Description : Shared constants and FSM state encoding for the count8_down
//               loadable down-counter/timer.
// Revision    : 1.0 - initial release
// ============================================================================
package count8_down_pkg;

  // Default counter and load-value width in bits
  localparam int c_DEFAULT_WIDTH = 8;

  // Two-bit state encoding; code 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/count8_down_dec_chain.sv
`default_nettype none
// ============================================================================
// Module      : count8_down_dec_chain
// Description : WIDTH-bit borrow-ripple decrementer. Each stage behaves like a
//               T flip-flop input: bit i toggles when the run enable is high
//               and every lower bit is 0 (the inverted form of an up-counter
//               carry chain). Purely combinational; the register lives in the
//               parent.
// Revision    : 1.0 - initial release
// ============================================================================
module count8_down_dec_chain #(
  parameter int WIDTH = 8
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_q
);

  // Toggle enables rippling up the chain
  logic [WIDTH-1:0] w_t;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign w_t[gi] = i_en;
      end else begin : g_upper
        // Borrow propagates through a bit only when that bit is already 0
        assign w_t[gi] = w_t[gi-1] & ~i_q[gi-1];
      end
      assign o_q[gi] = i_q[gi] ^ w_t[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/count8_down.sv
`default_nettype none
// ============================================================================
// Module      : count8_down
// Description : Loadable down-counter/timer with one-shot and auto-reload
//               modes. Counts down on En while running, pulses tc on the
//               1->0 step, and sets a sticky done flag on one-shot expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module count8_down
  import count8_down_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Res,
  input  logic             En,
  input  logic             Load,
  input  logic             AutoRe,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_done;
  logic             r_busy;

  logic             w_en_run;
  logic [WIDTH-1:0] w_cnt_dec;

  assign w_en_run = En & (r_state == ST_RUN);

  count8_down_dec_chain #(
    .WIDTH (WIDTH)
  ) u_dec_chain (
    .i_en (w_en_run),
    .i_q  (r_cnt),
    .o_q  (w_cnt_dec)
  );

  // FSM, load mux, reload register and registered tc/done/busy outputs
  always_ff @(posedge Clk) begin
    if (Res) begin
      r_state  <= ST_IDLE;
      r_cnt    <= c_ZERO;
      r_reload <= c_ZERO;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (Load) begin
      // Load restarts the run unconditionally and never produces a tc
      r_cnt    <= cnt_in;
      r_reload <= cnt_in;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
      if (cnt_in != c_ZERO) begin
        r_state <= ST_RUN;
        r_busy  <= 1'b1;
      end else begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tc <= 1'b0;
        end
        ST_RUN: begin
          r_tc <= 1'b0;
          if (En) begin
            if (r_cnt == c_ONE) begin
              r_tc <= 1'b1;
              if (AutoRe) begin
                r_cnt <= r_reload;
              end else begin
                r_cnt   <= c_ZERO;
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else if (r_cnt != c_ZERO) begin
              // Only decrement above 1, so the chain never borrows out
              r_cnt <= w_cnt_dec;
            end
          end
        end
        ST_DONE: begin
          r_tc   <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= c_ZERO;
          r_tc    <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt  = r_cnt;
  assign tc   = r_tc;
  assign done = r_done;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_count8_down.sv
`default_nettype none
// ============================================================================
// Module      : tb_count8_down
// Description : Self-checking bench for count8_down. A driver applies one
//               directed vector per clock and queues the hand-computed
//               response; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count8_down;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tc;
    logic       done;
    logic       busy;
  } exp_t;

  logic       Clk;
  logic       Res;
  logic       En;
  logic       Load;
  logic       AutoRe;
  logic [7:0] cnt_in;
  logic [7:0] cnt;
  logic       tc;
  logic       done;
  logic       busy;

  exp_t q_exp[$];
  int   n_total;
  int   n_bad;
  int   n_pushed;
  int   n_popped;
  bit   r_end_req;
  bit   r_end_done;

  count8_down #(
    .WIDTH (8)
  ) dut (
    .Clk    (Clk),
    .Res    (Res),
    .En     (En),
    .Load   (Load),
    .AutoRe (AutoRe),
    .cnt_in (cnt_in),
    .cnt    (cnt),
    .tc     (tc),
    .done   (done),
    .busy   (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Apply one vector for one clock and queue the state expected after it
  task automatic step(input logic res, input logic load, input logic en,
                      input logic autore, input logic [7:0] cin,
                      input logic [7:0] ecnt, input logic etc,
                      input logic edone, input logic ebusy);
    exp_t e;
    Res    = res;
    Load   = load;
    En     = en;
    AutoRe = autore;
    cnt_in = cin;
    @(posedge Clk);
    #1;
    e.cnt  = ecnt;
    e.tc   = etc;
    e.done = edone;
    e.busy = ebusy;
    q_exp.push_back(e);
    n_pushed = n_pushed + 1;
  endtask

  // Monitor: compares one queued expectation per falling edge
  initial begin
    exp_t e;
    n_total    = 0;
    n_bad      = 0;
    n_popped   = 0;
    r_end_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        n_popped = n_popped + 1;
        n_total  = n_total + 1;
        if (cnt !== e.cnt || tc !== e.tc || done !== e.done || busy !== e.busy) begin
          n_bad = n_bad + 1;
          $display("FAIL vec%0d: got cnt=%0d tc=%b done=%b busy=%b, want cnt=%0d tc=%b done=%b busy=%b",
                   n_popped, cnt, tc, done, busy, e.cnt, e.tc, e.done, e.busy);
        end
      end else if (r_end_req && !r_end_done) begin
        n_total = n_total + 1;
        if (n_popped != n_pushed) begin
          n_bad = n_bad + 1;
          $display("FAIL drain: popped=%0d want pushed=%0d", n_popped, n_pushed);
        end
        r_end_done = 1'b1;
      end
    end
  end

  initial begin
    n_pushed  = 0;
    r_end_req = 1'b0;
    Res = 1'b1; Load = 1'b0; En = 1'b0; AutoRe = 1'b0; cnt_in = 8'h00;

    // Reset overrides Load
    step(1, 1, 0, 0, 8'h55, 8'd0, 0, 0, 0);
    step(1, 1, 0, 0, 8'h55, 8'd0, 0, 0, 0);

    // One-shot from 3
    step(0, 1, 1, 0, 8'd3, 8'd3, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'd2, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'd1, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'd0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'd0, 8'd0, 0, 1, 0);

    // Auto-reload from 2: tc each time cnt returns to 2
    step(0, 1, 1, 1, 8'd2, 8'd2, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 8'd0, 8'd1, 0, 0, 1);
      step(0, 0, 1, 1, 8'd0, 8'd2, 1, 0, 1);
    end

    // Load 4 with gapped enable 1,0,0,1,1,0,1
    step(0, 1, 0, 0, 8'd4, 8'd4, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'd3, 0, 0, 1);
    step(0, 0, 0, 0, 8'd0, 8'd3, 0, 0, 1);
    step(0, 0, 0, 0, 8'd0, 8'd3, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'd2, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'd1, 0, 0, 1);
    step(0, 0, 0, 0, 8'd0, 8'd1, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'd0, 1, 1, 0);

    // Load 9, count to 1, reload mid-run at cnt==1 with En, then reset
    step(0, 1, 0, 0, 8'd9, 8'd9, 0, 0, 1);
    for (int i = 8; i >= 1; i--) step(0, 0, 1, 0, 8'd0, 8'(i), 0, 0, 1);
    step(0, 1, 1, 0, 8'd5, 8'd5, 0, 0, 1);
    step(1, 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);

    // Load zero stays idle and never ticks
    step(0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'd0, 8'd0, 0, 0, 0);

    // Auto-reload with 1: tc on every enabled cycle, then switch to one-shot
    step(0, 1, 0, 1, 8'd1, 8'd1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'd0, 8'd1, 1, 0, 1);
    step(0, 0, 0, 1, 8'd0, 8'd1, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'd0, 1, 1, 0);
    step(0, 0, 1, 1, 8'd0, 8'd0, 0, 1, 0);

    // Load leaves DONE
    step(0, 1, 1, 0, 8'hFE, 8'hFE, 0, 0, 1);
    step(0, 0, 1, 0, 8'd0, 8'hFD, 0, 0, 1);

    En = 1'b0; Load = 1'b0;
    r_end_req = 1'b1;
    for (int i = 0; i < 20 && !r_end_done; i++) @(posedge Clk);
    if (!r_end_done) begin
      $display("FAIL drain_timeout: got end_done=0 want 1");
      $fatal(1, "monitor did not finish");
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
